// File: rtl/tdc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tdc_cmd_sequencer
//
// Command store and byte sequencer for the TDC SPI link. A 32-entry ROM holds
// three command segments (INIT, START, READ). The selected segment is streamed
// to the SPI byte master one byte at a time over a valid/ready handshake. Each
// byte carries a frame-end marker, and the master uses it to release CS.
// Reply bytes received during READ frames are assembled into register words.
// In continuous mode the block loops START -> wait for INTB -> READ until
// cont_mode is dropped.
//
// Ports
//   clk, rst_n       system clock, asynchronous active-low reset
//   seg_start        pulse: run segment seg_sel (ignored while busy)
//   seg_sel[1:0]     0=INIT 1=START 2=READ 3=reserved (ignored)
//   cont_mode        sampled with a START request: loop START/WAIT/READ
//   intb_n           TDC interrupt, asynchronous, active low
//   tx_data/valid    byte to the SPI master, handshake with tx_ready
//   tx_last          byte ends its frame
//   rx_data/valid    byte shifted in during the matching tx byte
//   rd_word/rd_idx   assembled reply word (first byte = MSB) and frame index
//   rd_valid         1-cycle pulse qualifying rd_word/rd_idx
//   busy/done/err    activity flag, completion pulse, INTB timeout pulse
// -----------------------------------------------------------------------------
module tdc_cmd_sequencer #(
  parameter int          DATA_W      = 8,
  parameter int          RD_BYTES    = 3,
  parameter logic [7:0]  CFG2_VAL    = 8'h40,
  parameter logic [15:0] COARSE_OVF  = 16'h018F,
  parameter logic [7:0]  CFG1_VAL    = 8'h81,
  parameter logic [23:0] TIMEOUT_CYC = 24'd100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       seg_start,
  input  logic [1:0]                 seg_sel,
  input  logic                       cont_mode,
  input  logic                       intb_n,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       tx_last,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_valid,
  output logic [RD_BYTES*DATA_W-1:0] rd_word,
  output logic [1:0]                 rd_idx,
  output logic                       rd_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int         ROM_W      = DATA_W + 2;
  localparam int         RW         = RD_BYTES * DATA_W;
  localparam logic [4:0] BASE_INIT  = 5'd0;
  localparam logic [4:0] BASE_START = 5'd18;
  localparam logic [4:0] BASE_READ  = 5'd20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT_RX,
    S_END,
    S_WAIT_INT
  } state_t;

  // ROM word = {seg_last, frame_last, byte}
  function automatic logic [ROM_W-1:0] rom_word(input logic [4:0] a);
    logic [7:0] b;
    logic       fl;
    logic       sl;
    b = 8'h00;
    case (a)
      5'd0:    b = 8'h41;
      5'd1:    b = CFG2_VAL;
      5'd2:    b = 8'h42;
      5'd3:    b = 8'h00;
      5'd4:    b = 8'h43;
      5'd5:    b = 8'h07;
      5'd6:    b = 8'h44;
      5'd7:    b = COARSE_OVF[15:8];
      5'd8:    b = 8'h45;
      5'd9:    b = COARSE_OVF[7:0];
      5'd10:   b = 8'h46;
      5'd11:   b = 8'hFF;
      5'd12:   b = 8'h47;
      5'd13:   b = 8'hFF;
      5'd14:   b = 8'h48;
      5'd15:   b = 8'h00;
      5'd16:   b = 8'h49;
      5'd17:   b = 8'h00;
      5'd18:   b = 8'h40;
      5'd19:   b = CFG1_VAL;
      5'd20:   b = 8'h10;
      5'd24:   b = 8'h1B;
      5'd28:   b = 8'h1C;
      default: b = 8'h00;
    endcase
    // Write frames are two bytes (odd entries end them); read frames are four
    // bytes and the READ base is 4-aligned, so entries ending in 2'b11 close.
    fl = (a < BASE_READ) ? a[0] : (a[1:0] == 2'b11);
    sl = (a == 5'd17) || (a == 5'd19) || (a == 5'd31);
    return {sl, fl, DATA_W'(b)};
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4:0]        r_addr;
  logic [ROM_W-1:0]  r_rom_q;
  logic              r_loop;
  logic              r_intb_s1;
  logic              r_intb_s2;
  logic [23:0]       r_tmo_cnt;
  logic [RW-1:0]     r_rd_sh;
  logic [RW-1:0]     r_rd_word;
  logic [1:0]        r_rd_idx;
  logic              r_rd_valid;

  logic              w_start_ok;
  logic [4:0]        w_base;
  logic              w_seg_last;
  logic              w_frm_last;
  logic [DATA_W-1:0] w_byte;
  logic              w_intb_low;
  logic              w_tmo_hit;
  logic              w_loop_start;
  logic              w_loop_read;
  logic              w_in_read;
  logic [3:0]        w_rd_off;
  logic [RW-1:0]     w_sh_nxt;

  assign w_start_ok   = seg_start && (seg_sel != 2'd3);
  assign w_seg_last   = r_rom_q[ROM_W-1];
  assign w_frm_last   = r_rom_q[ROM_W-2];
  assign w_byte       = r_rom_q[DATA_W-1:0];
  assign w_intb_low   = ~r_intb_s2;
  assign w_tmo_hit    = (r_tmo_cnt == (TIMEOUT_CYC - 24'd1));
  // END decisions: which segment just finished is implied by the address.
  assign w_loop_start = r_loop && (r_addr == 5'd19);
  assign w_loop_read  = r_loop && (r_addr == 5'd31) && cont_mode;
  assign w_in_read    = (r_addr >= BASE_READ);
  assign w_rd_off     = 4'(r_addr - BASE_READ);
  // Shift the new byte in at the LSB end; the oldest byte ends up as MSB.
  assign w_sh_nxt     = RW'({r_rd_sh, rx_data});

  always_comb begin
    case (seg_sel)
      2'd1:    w_base = BASE_START;
      2'd2:    w_base = BASE_READ;
      default: w_base = BASE_INIT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_start_ok) w_state_nxt = S_FETCH;
      S_FETCH:    w_state_nxt = S_SEND;
      S_SEND:     if (tx_ready) w_state_nxt = S_WAIT_RX;
      S_WAIT_RX:  if (rx_valid) w_state_nxt = w_seg_last ? S_END : S_FETCH;
      S_END: begin
        if (w_loop_start)     w_state_nxt = S_WAIT_INT;
        else if (w_loop_read) w_state_nxt = S_FETCH;
        else                  w_state_nxt = S_IDLE;
      end
      S_WAIT_INT: begin
        if (w_intb_low)     w_state_nxt = S_FETCH;
        else if (w_tmo_hit) w_state_nxt = S_IDLE;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from state so they drop together with the
  // asynchronous reset.
  always_comb begin
    tx_valid = (r_state == S_SEND);
    tx_data  = (r_state == S_SEND) ? w_byte : '0;
    tx_last  = (r_state == S_SEND) && w_frm_last;
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_END) && !w_loop_start && !w_loop_read;
    err      = (r_state == S_WAIT_INT) && !w_intb_low && w_tmo_hit;
  end

  assign rd_word  = r_rd_word;
  assign rd_idx   = r_rd_idx;
  assign rd_valid = r_rd_valid;

  // INTB synchroniser, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_intb_s1 <= 1'b1;
      r_intb_s2 <= 1'b1;
    end else begin
      r_intb_s1 <= intb_n;
      r_intb_s2 <= r_intb_s1;
    end
  end

  // Address, loop flag, ROM read register, timeout counter, reply capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_rom_q    <= '0;
      r_loop     <= 1'b0;
      r_tmo_cnt  <= '0;
      r_rd_sh    <= '0;
      r_rd_word  <= '0;
      r_rd_idx   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rom_q    <= rom_word(r_addr);
      r_rd_valid <= 1'b0;
      if (r_state == S_WAIT_INT) r_tmo_cnt <= r_tmo_cnt + 24'd1;
      else                       r_tmo_cnt <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_addr <= w_base;
            r_loop <= (seg_sel == 2'd1) && cont_mode;
          end
        end
        S_WAIT_RX: begin
          if (rx_valid) begin
            if (!w_seg_last) r_addr <= r_addr + 5'd1;
            if (w_in_read) begin
              // First byte of each read frame is the address phase.
              if (w_rd_off[1:0] == 2'b00) begin
                r_rd_sh <= '0;
              end else begin
                r_rd_sh <= w_sh_nxt;
                if (w_frm_last) begin
                  r_rd_word  <= w_sh_nxt;
                  r_rd_idx   <= w_rd_off[3:2];
                  r_rd_valid <= 1'b1;
                end
              end
            end
          end
        end
        S_END: begin
          if (w_loop_read)       r_addr <= BASE_START;
          else if (!w_loop_start) r_loop <= 1'b0;
        end
        S_WAIT_INT: begin
          if (w_intb_low)     r_addr <= BASE_READ;
          else if (w_tmo_hit) r_loop <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_cmd_sequencer.sv
module tb_tdc_cmd_sequencer;

  localparam int          DATA_W = 8;
  localparam int          RD_B   = 3;
  localparam logic [7:0]  CFG2   = 8'h40;
  localparam logic [15:0] OVF    = 16'h018F;
  localparam logic [7:0]  CFG1   = 8'h81;

  logic              clk;
  logic              rst_n;
  logic              seg_start;
  logic [1:0]        seg_sel;
  logic              cont_mode;
  logic              intb_n;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [23:0]       rd_word;
  logic [1:0]        rd_idx;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              err;

  tdc_cmd_sequencer #(
    .DATA_W(DATA_W), .RD_BYTES(RD_B), .CFG2_VAL(CFG2), .COARSE_OVF(OVF),
    .CFG1_VAL(CFG1), .TIMEOUT_CYC(24'd100)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .seg_start(seg_start), .seg_sel(seg_sel),
    .cont_mode(cont_mode), .intb_n(intb_n), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .rx_data(rx_data), .rx_valid(rx_valid), .rd_word(rd_word),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Scoreboard queues: {last, byte}, reply bytes to return, {idx, word}
  logic [8:0]  exp_tx_q[$];
  logic [7:0]  rx_q[$];
  logic [25:0] exp_rd_q[$];

  int hs_cnt = 0;
  int last_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int stall_obs = 0;
  int stall_left = 0;
  bit rand_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_init();
    logic [7:0] regs[9];
    logic [7:0] vals[9];
    regs = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
    vals = '{CFG2, 8'h00, 8'h07, OVF[15:8], OVF[7:0], 8'hFF, 8'hFF, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) begin
      exp_tx_q.push_back({1'b0, regs[i]});
      exp_tx_q.push_back({1'b1, vals[i]});
      rx_q.push_back(8'($urandom));
      rx_q.push_back(8'($urandom));
    end
  endtask

  task automatic model_start();
    exp_tx_q.push_back({1'b0, 8'h40});
    exp_tx_q.push_back({1'b1, CFG1});
    rx_q.push_back(8'($urandom));
    rx_q.push_back(8'($urandom));
  endtask

  task automatic model_read(input logic [7:0] b[12]);
    logic [7:0] cmds[3];
    logic [1:0] f2;
    cmds = '{8'h10, 8'h1B, 8'h1C};
    for (int f = 0; f < 3; f++) begin
      f2 = f[1:0];
      exp_tx_q.push_back({1'b0, cmds[f]});
      exp_tx_q.push_back({1'b0, 8'h00});
      exp_tx_q.push_back({1'b0, 8'h00});
      exp_tx_q.push_back({1'b1, 8'h00});
      for (int k = 0; k < 4; k++) rx_q.push_back(b[4*f+k]);
      exp_rd_q.push_back({f2, b[4*f+1], b[4*f+2], b[4*f+3]});
    end
  endtask

  task automatic model_read_rand();
    logic [7:0] b[12];
    for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
    model_read(b);
  endtask

  // ---------------- SPI master model ----------------
  initial begin
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        tx_ready = 1'b0;
        rx_valid = 1'b0;
      end else begin
        rx_valid = 1'b0;
        if (tx_ready) begin
          tx_ready = 1'b0;
          rx_valid = 1'b1;
          if (rx_q.size() > 0) rx_data = rx_q.pop_front();
          else                 rx_data = 8'($urandom);
          if (rand_stall) stall_left = $urandom_range(0, 3);
        end else if (tx_valid) begin
          if (stall_left > 0) stall_left--;
          else                tx_ready = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] e;
    logic [25:0] r;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          stall_obs++;
          check("hold_valid", tx_valid, 1'b1);
          check("hold_data", tx_data, prev_data);
          check("hold_last", tx_last, prev_last);
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
        if (tx_valid && tx_ready) begin
          hs_cnt++;
          if (tx_last) last_cnt++;
          if (exp_tx_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL tx_unexpected: got byte %0h, no byte expected", tx_data);
          end else begin
            e = exp_tx_q.pop_front();
            check("tx_data", tx_data, e[7:0]);
            check("tx_last", tx_last, e[8]);
          end
        end
        if (rd_valid) begin
          if (exp_rd_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_unexpected: got word %0h idx %0d, none expected", rd_word, rd_idx);
          end else begin
            r = exp_rd_q.pop_front();
            check("rd_word", rd_word, r[23:0]);
            check("rd_idx", rd_idx, r[25:24]);
          end
        end
        if (done) done_cnt++;
        if (err)  err_cnt++;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_start(input logic [1:0] sel, input logic cm);
    @(posedge clk); #1;
    seg_sel   = sel;
    cont_mode = cm;
    seg_start = 1'b1;
    @(posedge clk); #1;
    seg_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (hs_cnt < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: byte count %0d, required %0d", name, hs_cnt, target);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_valid"}, tx_valid, 1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_tx_last"}, tx_last, 1'b0);
    check({tag, "_rd_word"}, rd_word, 24'h0);
    check({tag, "_rd_idx"}, rd_idx, 2'd0);
    check({tag, "_rd_valid"}, rd_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0, e0, h0, l0, s0, n;
    logic [1:0] sel;
    logic [7:0] fixb[12];

    rst_n = 1'b0; seg_start = 1'b0; seg_sel = 2'd0; cont_mode = 1'b0; intb_n = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // INIT with immediate answers, plus a READ request while busy
    d0 = done_cnt; l0 = last_cnt;
    model_init();
    pulse_start(2'd0, 1'b0);
    repeat (8) @(posedge clk);
    pulse_start(2'd2, 1'b0);
    wait_done(d0, 400, "t1_done");
    repeat (4) @(posedge clk);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_last_count", last_cnt - l0, 9);
    check("t1_tx_drained", exp_tx_q.size(), 0);
    check("t1_busy_low", busy, 1'b0);

    // INIT with tx_ready held off on the third byte
    d0 = done_cnt; h0 = hs_cnt; s0 = stall_obs;
    model_init();
    pulse_start(2'd0, 1'b0);
    wait_hs(h0 + 2, 200, "t2_first_bytes");
    stall_left = 5;
    wait_done(d0, 400, "t2_done");
    repeat (4) @(posedge clk);
    check("t2_stall_seen", (stall_obs - s0) >= 4, 1'b1);
    check("t2_done_once", done_cnt - d0, 1);
    check("t2_tx_drained", exp_tx_q.size(), 0);

    // READ with known reply bytes
    d0 = done_cnt;
    fixb = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'hBB, 8'h01, 8'h02, 8'h03,
             8'hCC, 8'h0A, 8'h0B, 8'h0C};
    model_read(fixb);
    pulse_start(2'd2, 1'b0);
    wait_done(d0, 400, "t3_done");
    repeat (4) @(posedge clk);
    check("t3_rd_drained", exp_rd_q.size(), 0);
    check("t3_tx_drained", exp_tx_q.size(), 0);

    // Random single segments with random master stalls
    rand_stall = 1;
    for (int it = 0; it < 10; it++) begin
      sel = 2'($urandom_range(0, 3));
      d0 = done_cnt;
      case (sel)
        2'd0: model_init();
        2'd1: model_start();
        2'd2: model_read_rand();
        default: ;
      endcase
      pulse_start(sel, 1'b0);
      if (sel == 2'd3) begin
        repeat (3) @(posedge clk);
        check("rand_reserved_busy", busy, 1'b0);
        check("rand_reserved_done", done_cnt - d0, 0);
      end else begin
        wait_done(d0, 800, "rand_done");
        repeat (3) @(posedge clk);
        check("rand_drained", exp_tx_q.size() + exp_rd_q.size(), 0);
      end
    end
    rand_stall = 0;
    repeat (3) @(posedge clk);
    stall_left = 0;

    // Continuous mode: two START/READ rounds, cont_mode dropped in the second
    d0 = done_cnt; e0 = err_cnt; h0 = hs_cnt;
    for (int it = 0; it < 2; it++) begin
      model_start();
      model_read_rand();
    end
    pulse_start(2'd1, 1'b1);
    for (int it = 0; it < 2; it++) begin
      wait_hs(h0 + it*14 + 2, 300, "t4_start_bytes");
      repeat (10) @(posedge clk);
      #1 intb_n = 1'b0;
      wait_hs(h0 + it*14 + 3, 100, "t4_read_begins");
      intb_n = 1'b1;
      if (it == 1) begin
        check("t4_no_early_done", done_cnt - d0, 0);
        cont_mode = 1'b0;
      end
    end
    wait_done(d0, 400, "t4_done");
    repeat (4) @(posedge clk);
    check("t4_done_once", done_cnt - d0, 1);
    check("t4_no_err", err_cnt - e0, 0);
    check("t4_tx_drained", exp_tx_q.size(), 0);
    check("t4_rd_drained", exp_rd_q.size(), 0);
    check("t4_busy_low", busy, 1'b0);

    // Continuous mode with INTB never asserted: timeout
    d0 = done_cnt; e0 = err_cnt; h0 = hs_cnt;
    model_start();
    pulse_start(2'd1, 1'b1);
    wait_hs(h0 + 2, 100, "t5_start_bytes");
    n = 0;
    while (err_cnt == e0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("t5_err_latency_ok", (n >= 98) && (n <= 106), 1'b1);
    #1;
    check("t5_busy_low", busy, 1'b0);
    cont_mode = 1'b0;
    repeat (5) @(posedge clk);
    check("t5_err_once", err_cnt - e0, 1);
    check("t5_no_done", done_cnt - d0, 0);

    // Reset while the sixth READ byte is being offered
    h0 = hs_cnt;
    model_read_rand();
    pulse_start(2'd2, 1'b0);
    wait_hs(h0 + 5, 100, "t6_first_bytes");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 50);
    check("t6_byte6_offered", tx_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    exp_tx_q.delete();
    rx_q.delete();
    exp_rd_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    model_init();
    pulse_start(2'd0, 1'b0);
    wait_done(d0, 400, "t6_init_done");
    repeat (4) @(posedge clk);
    check("t6_tx_drained", exp_tx_q.size(), 0);
    check("t6_done_once", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
